// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, sample type, controller states and index helper for the 8-point FFT
package fft_pkg;
    localparam int N_POINTS = 8;
    localparam int HALF_W   = 25;
    localparam int SAMPLE_W = 2 * HALF_W;

    typedef struct packed {
        logic signed [HALF_W-1:0] re;
        logic signed [HALF_W-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {FILL, RUN, DRAIN} fft_ctrl_state_t;

    function automatic logic [2:0] bitrev3(input logic [2:0] i);
        return {i[0], i[1], i[2]};
    endfunction
endpackage

// File: rtl/fft8_frame_ctrl.sv
// fft8_frame_ctrl: gathers 8-sample frames, holds them for the butterfly latency, streams results out
module fft8_frame_ctrl
    import fft_pkg::*;
#(
    parameter int PIPE_LAT   = 6,
    parameter bit BITREV_OUT = 1'b1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [SAMPLE_W-1:0]               s_data_i,
    input  logic                              s_valid_i,
    output logic                              s_ready_o,
    output logic [N_POINTS-1:0][SAMPLE_W-1:0] bfly_signal_o,
    input  logic [N_POINTS-1:0][SAMPLE_W-1:0] bfly_result_i,
    output logic [SAMPLE_W-1:0]               m_data_o,
    output logic                              m_valid_o,
    input  logic                              m_ready_i,
    output logic                              m_last_o,
    output logic                              busy_o,
    output logic                              frame_done_o
);
    fft_ctrl_state_t state, state_d;
    logic [N_POINTS-2:0][SAMPLE_W-1:0] in_buf;
    logic [N_POINTS-1:0][SAMPLE_W-1:0] out_buf;
    logic [2:0] fill_idx, drain_idx;
    logic [3:0] lat_cnt;
    logic in_hs, out_hs;

    always_comb begin
        s_ready_o = state == FILL;
        m_valid_o = state == DRAIN;
        in_hs     = s_valid_i & s_ready_o;
        out_hs    = m_valid_o & m_ready_i;
        m_last_o  = m_valid_o & (drain_idx == 3'd7);
        m_data_o  = m_valid_o ? out_buf[BITREV_OUT ? bitrev3(drain_idx) : drain_idx] : '0;
        busy_o    = (state != FILL) | (fill_idx != 3'd0);
        state_d   = (in_hs && fill_idx == 3'd7)       ? RUN   :
                    (state == RUN && lat_cnt == 4'd0)  ? DRAIN :
                    (out_hs && drain_idx == 3'd7)      ? FILL  : state;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= FILL;
        else       state <= state_d;
    end

    // The 8th sample goes straight to the butterfly, so in_buf only keeps the first seven.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_buf        <= '0;
            out_buf       <= '0;
            bfly_signal_o <= '0;
            fill_idx      <= '0;
            drain_idx     <= '0;
            lat_cnt       <= '0;
            frame_done_o  <= 1'b0;
        end else begin
            frame_done_o <= out_hs & (drain_idx == 3'd7);
            if (in_hs) begin
                fill_idx <= fill_idx + 3'd1;
                if (fill_idx != 3'd7) in_buf[fill_idx] <= s_data_i;
                else begin
                    bfly_signal_o <= {s_data_i, in_buf};
                    lat_cnt       <= 4'(PIPE_LAT);
                end
            end
            if (state == RUN) begin
                if (lat_cnt != 4'd0) lat_cnt <= lat_cnt - 4'd1;
                else begin
                    out_buf   <= bfly_result_i;
                    drain_idx <= '0;
                end
            end
            if (out_hs) drain_idx <= drain_idx + 3'd1;
        end
    end
endmodule
